// File: rtl/nec_divider_n.sv
`default_nettype none
// nec_divider_n: iterative restoring divider, 2QW/QW (wide) or QW/(QW/2), signed or unsigned. Rev 1.0
// Define NEC_DIV_EARLY_OVF_EN to reject oversized quotients at the accepting edge.
module nec_divider_n #(
  parameter int QW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic            start,
  input  logic            wide,
  input  logic            signed_mode,
  input  logic [2*QW-1:0] a,
  input  logic [QW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic            dbz,
  output logic [QW-1:0]   quot,
  output logic [QW-1:0]   rem
);
  localparam int HW = QW / 2;
  localparam int CW = $clog2(2 * QW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic            wide_q, signed_q, qneg_q, rneg_q;
  logic [QW-1:0]   acc_q, dvs_q;
  logic [2*QW-1:0] sh_q;
  logic [CW-1:0]   cnt_q;

  logic [2*QW-1:0] a_ext, a_mag;
  logic [QW-1:0]   b_ext, b_mag;
  logic            a_neg, b_neg, b_zero, early_ovf;

  // Sign-extend the active operand fields so one magnitude path serves both modes.
  always_comb begin
    a_ext  = wide ? a : {{QW{signed_mode & a[QW-1]}}, a[QW-1:0]};
    b_ext  = wide ? b : {{HW{signed_mode & b[HW-1]}}, b[HW-1:0]};
    a_neg  = signed_mode & a_ext[2*QW-1];
    b_neg  = signed_mode & b_ext[QW-1];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
  end

`ifdef NEC_DIV_EARLY_OVF_EN
  assign early_ovf = (a_mag >> (wide ? QW : HW)) >= {{QW{1'b0}}, b_mag};
`else
  assign early_ovf = 1'b0;
`endif

  logic [QW:0]   trial, trial_sub;
  logic          qbit;
  logic [QW-1:0] acc_next;

  assign trial     = {acc_q, sh_q[2*QW-1]};
  assign trial_sub = trial - {1'b0, dvs_q};
  assign qbit      = ~trial_sub[QW];
  assign acc_next  = qbit ? trial_sub[QW-1:0] : trial[QW-1:0];

  logic [2*QW-1:0] qmag, lim;
  logic [QW-1:0]   qs, rs, quot_res, rem_res;
  logic            ovf_fin;

  always_comb begin
    qmag = wide_q ? sh_q : {{QW{1'b0}}, sh_q[QW-1:0]};
    lim  = {{(2*QW-1){1'b0}}, 1'b1} << (wide_q ? QW - 1 : HW - 1);
    if (!signed_q)
      ovf_fin = wide_q ? (qmag[2*QW-1:QW] != '0) : (qmag[2*QW-1:HW] != '0);
    else if (qneg_q)
      ovf_fin = qmag > lim;
    else
      ovf_fin = qmag >= lim;
    qs       = qneg_q ? -qmag[QW-1:0] : qmag[QW-1:0];
    rs       = rneg_q ? -acc_q : acc_q;
    quot_res = wide_q ? qs : {{HW{1'b0}}, qs[HW-1:0]};
    rem_res  = wide_q ? rs : {{HW{1'b0}}, rs[HW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else if (ce)
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:    if (start && !b_zero && !early_ovf) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_next = FINISH;
      end
      FINISH: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      overflow <= 1'b0;
      dbz      <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      wide_q   <= 1'b0;
      signed_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      dvs_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            overflow <= 1'b0;
            dbz      <= 1'b0;
            wide_q   <= wide;
            signed_q <= signed_mode;
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            acc_q    <= '0;
            dvs_q    <= b_mag;
            // Left-align the dividend so the first step sees its MSB in both modes.
            sh_q     <= wide ? a_mag : {a_mag[QW-1:0], {QW{1'b0}}};
            cnt_q    <= wide ? CW'(2 * QW - 1) : CW'(QW - 1);
            if (b_zero) begin
              done <= 1'b1;
              dbz  <= 1'b1;
            end else if (early_ovf) begin
              done     <= 1'b1;
              overflow <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= acc_next;
          sh_q  <= {sh_q[2*QW-2:0], qbit};
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          if (ovf_fin) begin
            overflow <= 1'b1;
          end else begin
            quot <= quot_res;
            rem  <= rem_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nec_divider_n.sv
`default_nettype none
// Bench for nec_divider_n (QW=16): directed vector table, ce-toggle and reset-abort sequences,
// and random operations checked against a plain-arithmetic reference model.
module tb_nec_divider_n;
  localparam int QW = 16;

`ifdef NEC_DIV_EARLY_OVF_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, ce, start, wide, signed_mode;
  logic [2*QW-1:0] a;
  logic [QW-1:0]   b;
  logic            busy, done, overflow, dbz;
  logic [QW-1:0]   quot, rem;

  int n_total = 0;
  int n_pass  = 0;

  nec_divider_n #(.QW(QW)) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .wide(wide),
    .signed_mode(signed_mode), .a(a), .b(b), .busy(busy), .done(done),
    .overflow(overflow), .dbz(dbz), .quot(quot), .rem(rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic        w;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dbz;
    int          cyc;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: integer arithmetic on the sign-extended active fields.
  function automatic void model(input logic [31:0] ia, input logic [15:0] ib, input logic iw,
                                input logic is, input logic [15:0] pq, input logic [15:0] pr,
                                output logic [15:0] eq, output logic [15:0] er,
                                output logic eovf, output logic edbz, output int ecyc);
    int     rw;
    longint av, bv, q, r, lim, mask;
    rw = iw ? 16 : 8;
    if (iw) begin
      av = is ? longint'($signed(ia)) : longint'(ia);
      bv = is ? longint'($signed(ib)) : longint'(ib);
    end else begin
      av = is ? longint'($signed(ia[15:0])) : longint'(ia[15:0]);
      bv = is ? longint'($signed(ib[7:0])) : longint'(ib[7:0]);
    end
    eq = pq; er = pr; eovf = 1'b0; edbz = 1'b0; ecyc = 0;
    if (bv == 0) begin
      edbz = 1'b1;
      return;
    end
    mask = (longint'(1) << rw) - 1;
    lim  = longint'(1) << (rw - 1);
    if (EARLY && ((labs(av) >> rw) >= labs(bv))) begin
      eovf = 1'b1;
      return;
    end
    q = av / bv;
    r = av % bv;
    ecyc = (iw ? 32 : 16) + 1;
    eovf = is ? (q >= lim || q < -lim) : (q > mask);
    if (!eovf) begin
      eq = 16'(q & mask);
      er = 16'(r & mask);
    end
  endfunction

  task automatic run_op(input string nm, input logic [31:0] ia, input logic [15:0] ib,
                        input logic iw, input logic is, input logic [15:0] eq,
                        input logic [15:0] er, input logic eovf, input logic edbz, input int ecyc);
    int cyc;
    bit seen;
    @(negedge clk);
    a = ia; b = ib; wide = iw; signed_mode = is; start = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    seen = done;
    chk({nm, ".busy_at_accept"}, busy, ecyc != 0);
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      seen = done;
    end
    chk({nm, ".latency"}, cyc, ecyc);
    chk({nm, ".quot"}, quot, eq);
    chk({nm, ".rem"}, rem, er);
    chk({nm, ".overflow"}, overflow, eovf);
    chk({nm, ".dbz"}, dbz, edbz);
    @(posedge clk); #1;
    chk({nm, ".done_clears"}, {busy, done}, 2'b00);
  endtask

  logic [31:0] ra;
  logic [15:0] rb, pq, pr, eq, er;
  logic        rw, rs, eovf, edbz;
  int          ecyc;

  initial begin
    vt[0]  = '{32'h0001_0000, 16'h0003, 1'b1, 1'b0, 16'h5555, 16'h0001, 1'b0, 1'b0, 33};
    vt[1]  = '{32'hFFFF_FFF9, 16'h0002, 1'b1, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 33};
    vt[2]  = '{32'hFFFF_8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 33};
    vt[3]  = '{32'h0000_8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0, 33};
    vt[4]  = '{32'h0000_00FF, 16'h0010, 1'b0, 1'b0, 16'h000F, 16'h000F, 1'b0, 1'b0, 17};
    vt[5]  = '{32'h0000_0100, 16'h0001, 1'b0, 1'b0, 16'h000F, 16'h000F, 1'b1, 1'b0, EARLY ? 0 : 17};
    vt[6]  = '{32'h0000_1234, 16'h0000, 1'b1, 1'b0, 16'h000F, 16'h000F, 1'b0, 1'b1, 0};
    vt[7]  = '{32'h0000_1234, 16'hAB00, 1'b0, 1'b1, 16'h000F, 16'h000F, 1'b0, 1'b1, 0};
    vt[8]  = '{32'hDEAD_0064, 16'hFF07, 1'b0, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 17};
    vt[9]  = '{32'h0000_FFF9, 16'h0002, 1'b0, 1'b1, 16'h00FD, 16'h00FF, 1'b0, 1'b0, 17};
    vt[10] = '{32'h0000_FF80, 16'h0001, 1'b0, 1'b1, 16'h0080, 16'h0000, 1'b0, 1'b0, 17};
    vt[11] = '{32'h0000_0080, 16'h0001, 1'b0, 1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, 17};
    vt[12] = '{32'h8000_0000, 16'hFFFF, 1'b1, 1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, EARLY ? 0 : 33};

    reset = 1'b1; ce = 1'b0; start = 1'b0; wide = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.overflow", overflow, 1'b0);
    chk("reset.dbz", dbz, 1'b0);
    chk("reset.quot", quot, 16'h0000);
    chk("reset.rem", rem, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].w, vt[i].s,
             vt[i].q, vt[i].r, vt[i].ovf, vt[i].dbz, vt[i].cyc);

    // ce toggling with an ignored mid-run start; done must hold while ce is low.
    begin
      int ce_cnt;
      @(negedge clk);
      a = 32'h0001_0000; b = 16'h0003; wide = 1'b1; signed_mode = 1'b0; start = 1'b1; ce = 1'b1;
      @(posedge clk); #1;
      ce_cnt = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        ce = (i % 2 == 1);
        start = (i == 11);
        if (i == 11) begin
          a = 32'h0000_0100; wide = 1'b0; b = 16'h0001;
        end
        @(posedge clk); #1;
        if (ce) ce_cnt++;
        if (done) break;
      end
      start = 1'b0;
      chk("cetoggle.latency", ce_cnt, 33);
      chk("cetoggle.quot", quot, 16'h5555);
      chk("cetoggle.rem", rem, 16'h0001);
      chk("cetoggle.overflow", overflow, 1'b0);
      @(negedge clk);
      ce = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("cetoggle.done_holds", done, 1'b1);
      @(negedge clk);
      ce = 1'b1;
      @(posedge clk); #1;
      chk("cetoggle.done_clears", done, 1'b0);
    end

    // Reset mid-run aborts without a done pulse.
    begin
      bit seen;
      @(negedge clk);
      a = 32'hFFFF_FFF9; b = 16'h0002; wide = 1'b1; signed_mode = 1'b1; start = 1'b1; ce = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort.outputs", {busy, done, overflow, dbz, quot, rem}, 36'h0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) seen = 1'b1;
      end
      chk("abort.no_done", seen, 1'b0);
      run_op("after_abort", vt[0].a, vt[0].b, vt[0].w, vt[0].s,
             vt[0].q, vt[0].r, vt[0].ovf, vt[0].dbz, vt[0].cyc);
    end

    pq = 16'h5555; pr = 16'h0001;
    for (int k = 0; k < 150; k++) begin
      ra = $urandom;
      rb = 16'($urandom);
      rw = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = rb & 16'h000F;
        1: begin
          if (rb != 0) ra[31:16] = ra[31:16] % rb;
          if (rb[7:0] != 0) ra[15:8] = ra[15:8] % rb[7:0];
        end
        2: if ($urandom_range(0, 3) == 0) rb = 16'h0000;
        default: ;
      endcase
      model(ra, rb, rw, rs, pq, pr, eq, er, eovf, edbz, ecyc);
      run_op($sformatf("rnd%0d", k), ra, rb, rw, rs, eq, er, eovf, edbz, ecyc);
      pq = eq;
      pr = er;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
